// File: rtl/tank_sprite_rom_arbiter_pkg.sv
// Shared types and sizes for the tank sprite ROM arbiter and its round-robin picker.
package tank_sprite_pkg;

    localparam int SPRITE_ADDR_W = 10;
    localparam int SPRITE_DATA_W = 4;
    localparam int NUM_REQ       = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/tank_sprite_rom_arbiter_rr_pick.sv
// Combinational two-way round-robin picker; masked requesters are skipped unless nobody else wants the ROM.
module tank_sprite_rr_pick
    import tank_sprite_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    rr_ptr,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic [1:0] elig;

    always_comb begin
        elig  = valid & ~mask;
        grant = 2'b00;
        if (elig == 2'b00) begin
            elig = valid;
        end
        if (rr_ptr == 1'b0) begin
            if (elig[0])      grant = 2'b01;
            else if (elig[1]) grant = 2'b10;
        end else begin
            if (elig[1])      grant = 2'b10;
            else if (elig[0]) grant = 2'b01;
        end
    end

endmodule

// File: rtl/tank_sprite_rom_arbiter.sv
// Shares one synchronous tank sprite ROM between two renderers with round-robin and a bounded lock.
// Build option TANK_ROM_OUTREG_EN adds an internal register on rom_q (two-cycle response latency).
module tank_sprite_rom_arbiter
    import tank_sprite_pkg::*;
#(
    parameter int ADDR_W   = SPRITE_ADDR_W,
    parameter int DATA_W   = SPRITE_DATA_W,
    parameter int MAX_LOCK = 8
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [1:0]          req_valid,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [1:0]          req_lock,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [DATA_W-1:0]   rom_q
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    lock_state_t state_q, state_d;
    req_id_t     owner_q, owner_d;
    req_id_t     rr_ptr_q, rr_ptr_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d, cnt_next;
    logic        force_rel_q, force_rel_d;

    logic        hold_owner;
    logic [1:0]  mask;
    logic [1:0]  pick_grant;
    logic [1:0]  grant;
    logic        xfer;
    req_id_t     gid;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= MAX_LOCK_C) ? MAX_LOCK_C : c + 8'd1;
    endfunction

    // The owner keeps the ROM only while it is both requesting and still asking for the lock.
    assign hold_owner = (state_q == LOCKED) && req_valid[owner_q] && req_lock[owner_q];
    assign mask       = force_rel_q ? (2'b01 << owner_q) : 2'b00;

    tank_sprite_rr_pick u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .mask   (mask),
        .grant  (pick_grant)
    );

    assign grant     = hold_owner ? (2'b01 << owner_q) : pick_grant;
    assign req_ready = grant;
    assign xfer      = |grant;
    assign gid       = grant[1];

    always_comb begin
        rom_address = '0;
        if (grant[0])      rom_address = req_addr[0 +: ADDR_W];
        else if (grant[1]) rom_address = req_addr[ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d     = UNLOCKED;
        owner_d     = owner_q;
        lock_cnt_d  = '0;
        force_rel_d = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        cnt_next    = '0;
        if (xfer) begin
            rr_ptr_d = ~gid;
            if (req_lock[gid]) begin
                cnt_next = hold_owner ? sat_inc(lock_cnt_q) : 8'd1;
                owner_d  = gid;
                if (cnt_next >= MAX_LOCK_C) begin
                    force_rel_d = 1'b1;
                end else begin
                    state_d    = LOCKED;
                    lock_cnt_d = cnt_next;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNLOCKED;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            lock_cnt_q  <= '0;
            force_rel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            force_rel_q <= force_rel_d;
        end
    end

    // Stage p0: tag for the ROM read issued this cycle
    rsp_tag_t          tag_p0;
    rsp_tag_t          tag_out;
    logic [DATA_W-1:0] data_out;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) tag_p0 <= '0;
        else          tag_p0 <= '{valid: xfer, id: gid};
    end

`ifdef TANK_ROM_OUTREG_EN
    // Stage p1: registered ROM data with its tag
    rsp_tag_t          tag_p1;
    logic [DATA_W-1:0] rom_q_p1;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) tag_p1 <= '0;
        else          tag_p1 <= tag_p0;
    end

    always_ff @(posedge vga_clk) begin
        rom_q_p1 <= rom_q;
    end

    assign tag_out  = tag_p1;
    assign data_out = rom_q_p1;
`else
    assign tag_out  = tag_p0;
    assign data_out = rom_q;
`endif

    assign rsp_valid = tag_out.valid ? (2'b01 << tag_out.id) : 2'b00;
    assign rsp_data  = tag_out.valid ? data_out : '0;

endmodule

// File: tb/tb_tank_sprite_rom_arbiter.sv
// Directed bench for tank_sprite_rom_arbiter with a behavioural sprite ROM and response scoreboard.
module tb_tank_sprite_rom_arbiter;

`ifdef TANK_ROM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [19:0] req_addr;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [3:0]  rsp_data;
    logic [9:0]  rom_address;
    logic [3:0]  rom_q = 4'h0;

    typedef struct {
        int         due;
        logic       id;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    tank_sprite_rom_arbiter #(.ADDR_W(10), .DATA_W(4), .MAX_LOCK(4)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_lock    (req_lock),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [3:0] rom_fn(input logic [9:0] a);
        return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] v, input logic [9:0] a0,
                        input logic [9:0] a1, input logic [1:0] lk, input logic [1:0] exp_rdy);
        exp_t e;
        @(posedge vga_clk);
        #1;
        reset_n   = ~rst;
        req_valid = v;
        req_addr  = {a1, a0};
        req_lock  = lk;
        #3;
        if (rst) sb.delete();
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.id));
            chk("rsp_data",  32'(rsp_data),  32'(e.data));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            chk("rsp_data_idle",  32'(rsp_data),  32'd0);
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rom_address", 32'(rom_address),
            32'(exp_rdy == 2'b01 ? a0 : (exp_rdy == 2'b10 ? a1 : 10'd0)));
        if (exp_rdy != 2'b00) begin
            e.due  = cyc + LAT;
            e.id   = exp_rdy[1];
            e.data = rom_fn(exp_rdy[1] ? a1 : a0);
            sb.push_back(e);
        end
        cyc++;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_lock  = 2'b00;

        // reset state
        repeat (3) step(1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);

        // single request, then idle cycles hold the pointer at requester 1
        step(1'b0, 2'b01, 10'h155, 10'h000, 2'b00, 2'b01);
        repeat (3) step(1'b0, 2'b00, 10'h155, 10'h2AA, 2'b00, 2'b00);
        step(1'b0, 2'b11, 10'h020, 10'h2A7, 2'b00, 2'b10);
        repeat (2) step(1'b0, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);

        // alternation after reset
        repeat (2) step(1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b11, 10'(10'h103 + 10'(i * 5)), 10'(10'h231 + 10'(i * 3)), 2'b00,
                 (i % 2 == 0) ? 2'b01 : 2'b10);

        // lock bound of four grants
        for (int i = 0; i < 4; i++)
            step(1'b0, 2'b11, 10'(10'h040 + 10'(i)), 10'h3F0, 2'b01, 2'b01);
        step(1'b0, 2'b11, 10'h044, 10'h3F1, 2'b01, 2'b10);

        // early unlock after two grants
        step(1'b0, 2'b11, 10'h0A1, 10'h1B2, 2'b01, 2'b01);
        step(1'b0, 2'b11, 10'h0A2, 10'h1B3, 2'b01, 2'b01);
        step(1'b0, 2'b11, 10'h0A3, 10'h1B4, 2'b00, 2'b10);
        step(1'b0, 2'b11, 10'h0A4, 10'h1B5, 2'b00, 2'b01);
        step(1'b0, 2'b11, 10'h0A5, 10'h1B6, 2'b00, 2'b10);

        // locked owner drops valid: other requester granted the same cycle
        step(1'b0, 2'b11, 10'h311, 10'h0C8, 2'b01, 2'b01);
        step(1'b0, 2'b10, 10'h312, 10'h0C9, 2'b01, 2'b10);
        repeat (2) step(1'b0, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);

        // reset in flight discards the response and resets the pointer
        step(1'b0, 2'b01, 10'h3C3, 10'h000, 2'b00, 2'b01);
        repeat (2) step(1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);
        repeat (2) step(1'b0, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);
        step(1'b0, 2'b11, 10'h0EE, 10'h1DD, 2'b00, 2'b01);
        repeat (3) step(1'b0, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
